lfsr_bist_ctrl: RTL and testbench
=================================

LFSR_BIST_CTRL -- requirements
Module: lfsr_bist_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, LFSR/memory address width.
REQ-002 Parameter DATA_W, default 32, LFSR/memory data width.
REQ-003 Parameter N_STEPS, default 1023, addresses per pass (maximal 10-bit LFSR period).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level; sampled in IDLE or DONE only.
REQ-007 lfsr_addr  in  ADDR_W  current LFSR address word.
REQ-008 lfsr_data  in  DATA_W  current LFSR data word.
REQ-009 lfsr_en_addr, lfsr_en_data  out  1 each  advance LFSR at next edge.
REQ-010 lfsr_reload  out  1  one-cycle pulse; LFSR returns to seed at next edge.
REQ-011 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_we, mem_re  out  1 each.
REQ-012 mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_re.
REQ-013 busy, done, pass  out  1 each; err_count  out  ADDR_W; first_err_addr  out  ADDR_W.

Function
REQ-014 The FSM SHALL have states IDLE, RLD_W, WRITE, RLD_R, READ, DRAIN, DONE.
REQ-015 IDLE or DONE with start=1 -> RLD_W; clears err_count, first_err_addr, pass, done.
REQ-016 RLD_W and RLD_R: lfsr_reload=1 for exactly one cycle, no memory access, enables low.
REQ-017 WRITE: mem_we=1, mem_addr=lfsr_addr, mem_wdata=lfsr_data, both enables=1, combinational from state.
REQ-018 The step counter SHALL count 0..N_STEPS-1 in WRITE and READ; last step -> RLD_R or DRAIN respectively.
REQ-019 READ: mem_re=1, mem_addr=lfsr_addr, both enables=1; lfsr_data and lfsr_addr registered as expected word/address.
REQ-020 Compare stage, one cycle after each mem_re: mem_rdata != expected -> err_count+1; first mismatch loads first_err_addr.
REQ-021 DRAIN: one cycle for the final compare, no access; -> DONE.
REQ-022 DONE: done=1, pass=(err_count==0), held until start or rst.
REQ-023 busy=1 in every state except IDLE and DONE.
REQ-024 start while busy SHALL be ignored; start held high in DONE restarts immediately.
REQ-025 err_count SHALL NOT wrap; its maximum is N_STEPS, which fits in ADDR_W.
REQ-026 first_err_addr=0 means no error; a 10-bit LFSR never emits address 0.
REQ-027 mem_we and mem_re SHALL never both be 1.
REQ-028 Latency: done rises 2*N_STEPS+4 edges after the edge sampling start (2050 at default).

Reset
REQ-029 rst SHALL force IDLE and zero every output, counter, compare-valid bit and expected register at the next edge.
REQ-030 rst mid-WRITE/READ: mem_we/mem_re/enables low from the next edge; no pending compare counted.
REQ-031 rst has priority over start in the same cycle.

Structure
REQ-032 Package lfsr_bist_pkg SHALL hold the state enum and default ADDR_W, DATA_W, N_STEPS constants.
REQ-033 The compare/error accumulator SHALL be sub-module lfsr_bist_cmp: valid, expected, addr, rdata in; err_count, first_err_addr out; clear input.
REQ-034 The bench SHALL pair the DUT with the existing lfsr block (clk, rstn=~rst, reload added) and a 1024x32 behavioural RAM.

Verification
REQ-035 Clean RAM, start pulse -> 1023 writes, 1023 reads, done at edge 2050, pass=1, err_count=0, first_err_addr=0.
REQ-036 Force RAM bit 0 stuck-at-1 at the 3rd read address -> pass=0, err_count=1, first_err_addr equals that address.
REQ-037 Corrupt every read word -> err_count=1023 (0x3FF), no wrap, pass=0.
REQ-038 rst asserted at WRITE step 500 -> next edge all outputs 0, IDLE; a new start completes with pass=1.
REQ-039 start held high across whole run -> ignored while busy; second run starts the cycle after DONE, done low for one cycle.
REQ-040 Assertions throughout: never mem_we&mem_re; lfsr_reload exactly 2 one-cycle pulses per run.

Source files
------------

// File: rtl/lfsr_bist_pkg.sv
// Shared definitions for the LFSR-driven memory BIST controller.
// Holds the default geometry (address width, data width, steps per pass)
// and the controller state encoding.
package lfsr_bist_pkg;

    localparam int unsigned ADDR_W_DEFAULT  = 10;
    localparam int unsigned DATA_W_DEFAULT  = 32;
    // A maximal 10-bit LFSR visits every nonzero address exactly once.
    localparam int unsigned N_STEPS_DEFAULT = 1023;

    typedef enum logic [2:0] {
        StIdle,
        StRldW,
        StWrite,
        StRldR,
        StRead,
        StDrain,
        StDone
    } bist_state_e;

endpackage

// File: rtl/lfsr_bist_cmp.sv
// Read-data compare and error accumulator.
// A read issued in cycle c returns data in cycle c+1; the expected word and
// address are captured alongside the read and compared when the data arrives.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           zero the accumulators (start of a new test)
//   valid           a read is being issued this cycle
//   expected, addr  expected word / address of that read
//   rdata           memory read data, valid one cycle after valid
//   err_count       number of miscompares so far (saturating)
//   first_err_addr  address of the first miscompare, 0 if none
module lfsr_bist_cmp
    import lfsr_bist_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              valid,
    input  logic [DATA_W-1:0] expected,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    logic              valid_q;
    logic [DATA_W-1:0] exp_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic              mismatch;

    always_comb begin
        mismatch = valid_q && (rdata != exp_q);
        err_d    = err_q;
        first_d  = first_q;
        if (clear) begin
            err_d   = '0;
            first_d = '0;
        end else if (mismatch) begin
            // Saturate rather than wrap; a count of zero marks "no error yet".
            if (err_q != '1) begin
                err_d = err_q + 1'b1;
            end
            if (err_q == '0) begin
                first_d = addr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            exp_q   <= '0;
            addr_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            valid_q <= valid;
            exp_q   <= expected;
            addr_q  <= addr;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign err_count      = err_q;
    assign first_err_addr = first_q;

endmodule

// File: rtl/lfsr_bist_ctrl.sv
// LFSR-driven memory BIST controller.
// One pass writes N_STEPS LFSR words to LFSR addresses, reloads the LFSR to
// its seed, reads the same sequence back and counts miscompares.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       level; honoured only in IDLE or DONE
//   lfsr_addr, lfsr_data        current LFSR address / data words
//   lfsr_en_addr, lfsr_en_data  advance the LFSRs at the next edge
//   lfsr_reload                 return the LFSRs to their seed at the next edge
//   mem_addr, mem_wdata         memory address / write data
//   mem_we, mem_re              memory write / read strobes (never both)
//   mem_rdata                   read data, valid one cycle after mem_re
//   busy, done, pass            status
//   err_count, first_err_addr   miscompare count, first failing address
module lfsr_bist_ctrl
    import lfsr_bist_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned N_STEPS = N_STEPS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] lfsr_addr,
    input  logic [DATA_W-1:0] lfsr_data,
    output logic              lfsr_en_addr,
    output logic              lfsr_en_data,
    output logic              lfsr_reload,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(N_STEPS - 1);

    bist_state_e       state_q, state_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic              start_go;

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        start_go     = 1'b0;
        lfsr_en_addr = 1'b0;
        lfsr_en_data = 1'b0;
        lfsr_reload  = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        done         = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    start_go = 1'b1;
                    step_d   = '0;
                    state_d  = StRldW;
                end
            end
            StRldW: begin
                lfsr_reload = 1'b1;
                step_d      = '0;
                state_d     = StWrite;
            end
            StWrite: begin
                mem_we       = 1'b1;
                mem_addr     = lfsr_addr;
                mem_wdata    = lfsr_data;
                lfsr_en_addr = 1'b1;
                lfsr_en_data = 1'b1;
                if (step_q == LAST_STEP) begin
                    step_d  = '0;
                    state_d = StRldR;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            StRldR: begin
                lfsr_reload = 1'b1;
                step_d      = '0;
                state_d     = StRead;
            end
            StRead: begin
                mem_re       = 1'b1;
                mem_addr     = lfsr_addr;
                lfsr_en_addr = 1'b1;
                lfsr_en_data = 1'b1;
                if (step_q == LAST_STEP) begin
                    step_d  = '0;
                    state_d = StDrain;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            // Lets the compare stage see the data of the final read.
            StDrain: begin
                state_d = StDone;
            end
            StDone: begin
                done = 1'b1;
                if (start) begin
                    start_go = 1'b1;
                    step_d   = '0;
                    state_d  = StRldW;
                end
            end
            default: begin
                state_d = StIdle;
                step_d  = '0;
            end
        endcase

        busy = (state_q != StIdle) && (state_q != StDone);
        pass = done && (err_count == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    lfsr_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk            (clk),
        .rst            (rst),
        .clear          (start_go),
        .valid          (mem_re),
        .expected       (lfsr_data),
        .addr           (lfsr_addr),
        .rdata          (mem_rdata),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// Bench for lfsr_bist_ctrl: pairs the controller with an LFSR pair and a
// 1024x32 RAM with fault injection. Expected memory accesses are queued
// when a run is launched and popped as the DUT issues them.
module tb_lfsr_bist_ctrl;
    import lfsr_bist_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NS = 1023;
    localparam int TIMEOUT = 5000;
    localparam logic [AW-1:0] ASEED = 10'h001;
    localparam logic [DW-1:0] DSEED = 32'h0000_0001;

    logic          clk, rst, start;
    logic [AW-1:0] lfsr_addr;
    logic [DW-1:0] lfsr_data;
    logic          lfsr_en_addr, lfsr_en_data, lfsr_reload;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we, mem_re, busy, done, pass;
    logic [AW-1:0] err_count, first_err_addr;
    logic          rstn;

    lfsr_bist_ctrl #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .N_STEPS (NS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .lfsr_addr      (lfsr_addr),
        .lfsr_data      (lfsr_data),
        .lfsr_en_addr   (lfsr_en_addr),
        .lfsr_en_data   (lfsr_en_data),
        .lfsr_reload    (lfsr_reload),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_re         (mem_re),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // x^10 + x^7 + 1 and x^32 + x^22 + x^2 + x + 1, both maximal.
    function automatic logic [AW-1:0] addr_next(input logic [AW-1:0] a);
        return {a[AW-2:0], a[9] ^ a[6]};
    endfunction

    function automatic logic [DW-1:0] data_next(input logic [DW-1:0] d);
        return {d[DW-2:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
    endfunction

    // LFSR block: active-low reset, plus reload to seed.
    assign rstn = ~rst;
    always @(posedge clk) begin
        if (!rstn || lfsr_reload) begin
            lfsr_addr <= ASEED;
            lfsr_data <= DSEED;
        end else begin
            if (lfsr_en_addr) lfsr_addr <= addr_next(lfsr_addr);
            if (lfsr_en_data) lfsr_data <= data_next(lfsr_data);
        end
    end

    // RAM with registered read; mode 1 = bit0 stuck-at-1 at fault_addr,
    // mode 2 = every read word inverted.
    logic [DW-1:0] ram [1024];
    logic [DW-1:0] rd_q;
    logic [AW-1:0] ra_q;
    int            mode;
    logic [AW-1:0] fault_addr;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) begin
            rd_q <= ram[mem_addr];
            ra_q <= mem_addr;
        end
    end

    always_comb begin
        mem_rdata = rd_q;
        if (mode == 1 && ra_q == fault_addr) mem_rdata[0] = 1'b1;
        if (mode == 2) mem_rdata = ~rd_q;
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } acc_t;

    typedef struct {
        string name;
        int    mode;
        logic  exp_pass;
        int    exp_err;
        int    first_idx;  // read index of first miscompare, -1 for none
    } vec_t;

    acc_t          sb[$];
    logic [AW-1:0] exp_a [NS];
    logic [DW-1:0] exp_d [NS];
    vec_t          tbl [3];
    int            vectors = 0;
    int            miscompares = 0;
    int            rld_cnt = 0;
    int            wr_seen = 0;
    logic          prev_rld = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        chk("we_re_exclusive", {127'd0, mem_we & mem_re}, 128'd0);
        if (lfsr_reload) begin
            rld_cnt++;
            chk("reload_one_cycle", {127'd0, prev_rld}, 128'd0);
        end
        prev_rld = lfsr_reload;
        if (mem_we || mem_re) begin
            if (mem_we) wr_seen++;
            chk("lfsr_enables", {126'd0, lfsr_en_addr, lfsr_en_data}, 128'd3);
            if (sb.size() == 0) begin
                chk("sb_underflow", 128'd1, 128'd0);
            end else begin
                acc_t e;
                e = sb.pop_front();
                chk("acc_kind", {127'd0, mem_we}, {127'd0, e.we});
                chk("acc_addr", {118'd0, mem_addr}, {118'd0, e.a});
                if (mem_we) chk("acc_wdata", {96'd0, mem_wdata}, {96'd0, e.d});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic begin_run();
        for (int i = 0; i < NS; i++) sb.push_back('{we: 1'b1, a: exp_a[i], d: exp_d[i]});
        for (int i = 0; i < NS; i++) sb.push_back('{we: 1'b0, a: exp_a[i], d: exp_d[i]});
        rld_cnt = 0;
        wr_seen = 0;
    endtask

    // Counts edges with the start-sampling edge as edge 1.
    task automatic wait_done(input int lat0, input bit hold, output int lat);
        lat = lat0;
        do begin
            tick();
            lat++;
            if (!hold) start = 1'b0;
        end while (!done && lat < TIMEOUT);
        if (!done) chk("done_timeout", 128'd0, 128'd1);
    endtask

    task automatic check_result(input string tag, input logic p, input int e, input int f);
        chk({tag, "_done"}, {127'd0, done}, 128'd1);
        chk({tag, "_busy"}, {127'd0, busy}, 128'd0);
        chk({tag, "_pass"}, {127'd0, pass}, {127'd0, p});
        chk({tag, "_err_count"}, {118'd0, err_count}, 128'(e));
        chk({tag, "_first_err"}, {118'd0, first_err_addr}, 128'(f));
        chk({tag, "_sb_empty"}, 128'(sb.size()), 128'd0);
        chk({tag, "_reloads"}, 128'(rld_cnt), 128'd2);
    endtask

    function automatic logic [127:0] all_outs();
        return {58'd0, lfsr_en_addr, lfsr_en_data, lfsr_reload, mem_addr, mem_wdata,
                mem_we, mem_re, busy, done, pass, err_count, first_err_addr};
    endfunction

    initial begin
        int lat;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        a = ASEED;
        d = DSEED;
        for (int i = 0; i < NS; i++) begin
            exp_a[i] = a;
            exp_d[i] = d;
            a = addr_next(a);
            d = data_next(d);
        end
        fault_addr = exp_a[2];

        tbl[0] = '{name: "clean",   mode: 0, exp_pass: 1'b1, exp_err: 0,  first_idx: -1};
        tbl[1] = '{name: "stuck1",  mode: 1, exp_pass: 1'b0, exp_err: 1,  first_idx: 2};
        tbl[2] = '{name: "corrupt", mode: 2, exp_pass: 1'b0, exp_err: NS, first_idx: 0};

        mode  = 0;
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        chk("reset_outputs", all_outs(), 128'd0);
        rst = 1'b0;
        tick();
        chk("idle_outputs", all_outs(), 128'd0);

        for (int i = 0; i < 3; i++) begin
            mode = tbl[i].mode;
            begin_run();
            start = 1'b1;
            wait_done(0, 1'b0, lat);
            chk({tbl[i].name, "_latency"}, 128'(lat), 128'(2 * NS + 4));
            check_result(tbl[i].name, tbl[i].exp_pass, tbl[i].exp_err,
                         tbl[i].first_idx < 0 ? 0 : int'(exp_a[tbl[i].first_idx]));
            if (i == 0) begin
                tick();
                tick();
                chk("done_held", {126'd0, done, pass}, 128'd3);
            end
        end

        // Reset in the middle of the write pass, then a clean rerun.
        mode = 0;
        begin_run();
        start = 1'b1;
        lat = 0;
        do begin
            tick();
            start = 1'b0;
            lat++;
        end while (wr_seen < 501 && lat < TIMEOUT);
        chk("mid_write_reached", {127'd0, mem_we}, 128'd1);
        rst = 1'b1;
        tick();
        chk("mid_write_reset_outs", all_outs(), 128'd0);
        sb.delete();
        rst = 1'b0;
        tick();
        chk("post_reset_idle", all_outs(), 128'd0);
        begin_run();
        start = 1'b1;
        wait_done(0, 1'b0, lat);
        chk("rerun_latency", 128'(lat), 128'(2 * NS + 4));
        check_result("rerun", 1'b1, 0, 0);

        // Start held high: ignored while busy, restarts straight out of DONE.
        begin_run();
        start = 1'b1;
        wait_done(0, 1'b1, lat);
        chk("held_latency", 128'(lat), 128'(2 * NS + 4));
        check_result("held1", 1'b1, 0, 0);
        begin_run();
        tick();
        chk("held_restart", {125'd0, done, busy, lfsr_reload}, 128'b011);
        wait_done(1, 1'b1, lat);
        start = 1'b0;
        chk("held2_latency", 128'(lat), 128'(2 * NS + 4));
        check_result("held2", 1'b1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
